// File: rtl/jpeg_level_shift_serializer.sv
// JPEG level-shift serializer: captures an 8x8 IDCT block, adds +128,
// clamps each sample to a pixel and streams 64 pixels in raster order.
module jpeg_level_shift_serializer #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 8,
  parameter int SHIFT = 128
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               blk_valid,
  output logic               blk_ready,
  input  logic [64*IN_W-1:0] blk_data,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [OUT_W-1:0]   pix_data,
  output logic [2:0]         pix_row,
  output logic [2:0]         pix_col,
  output logic               pix_last
);

  localparam int SW = IN_W + 1;
  localparam logic signed [SW-1:0] SHIFT_S = SW'(SHIFT);
  localparam logic signed [SW-1:0] MAX_S   = SW'((1 << OUT_W) - 1);

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  state_t                state_q, state_d;
  logic [5:0]            idx_q, idx_d;
  logic [OUT_W-1:0]      buf_q [64];
  logic [OUT_W-1:0]      sat_d [64];
  logic signed [SW-1:0]  s;
  logic                  blk_hs;
  logic                  pix_hs;

  assign pix_valid = (state_q == STREAM);
  assign pix_data  = pix_valid ? buf_q[idx_q] : '0;
  assign pix_row   = idx_q[5:3];
  assign pix_col   = idx_q[2:0];
  assign pix_last  = pix_valid && (idx_q == 6'd63);
  assign pix_hs    = pix_valid && pix_ready;
  assign blk_ready = (state_q == IDLE) || (pix_hs && pix_last);
  assign blk_hs    = blk_valid && blk_ready;

  // Level shift and clamp every incoming element before capture
  always_comb begin
    s = '0;
    for (int k = 0; k < 64; k++) begin
      s = $signed({blk_data[k*IN_W+IN_W-1],
                   blk_data[k*IN_W +: IN_W]}) + SHIFT_S;
      if (s[SW-1])
        sat_d[k] = '0;
      else if (s > MAX_S)
        sat_d[k] = '1;
      else
        sat_d[k] = s[OUT_W-1:0];
    end
  end

  // Pixel buffer, written only on a block handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 64; k++)
        buf_q[k] <= '0;
    end else if (blk_hs) begin
      for (int k = 0; k < 64; k++)
        buf_q[k] <= sat_d[k];
    end
  end

  // State and pixel index registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next state: stream 64 pixels, reload on the final handshake if offered
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (blk_hs) begin
          state_d = STREAM;
          idx_d   = '0;
        end
      end
      (state_q == STREAM): begin
        if (pix_hs) begin
          if (!pix_last) begin
            idx_d = idx_q + 6'd1;
          end else begin
            idx_d   = '0;
            state_d = blk_hs ? STREAM : IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_jpeg_level_shift_serializer.sv
// Bench for jpeg_level_shift_serializer: scoreboard of expected
// pixels pushed at block presentation, popped on each pixel handshake.
module tb_jpeg_level_shift_serializer;

  logic          clk;
  logic          rst_n;
  logic          blk_valid;
  logic          blk_ready;
  logic [1023:0] blk_data;
  logic          pix_valid;
  logic          pix_ready;
  logic [7:0]    pix_data;
  logic [2:0]    pix_row;
  logic [2:0]    pix_col;
  logic          pix_last;

  logic [14:0] exp_q [$];
  int          pass;
  int          tot;
  int          cyc_n;

  jpeg_level_shift_serializer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_data  (pix_data),
    .pix_row   (pix_row),
    .pix_col   (pix_col),
    .pix_last  (pix_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ref_sat(input logic [15:0] x);
    int v;
    v = int'($signed(x)) + 128;
    if (v < 0) return 8'd0;
    if (v > 255) return 8'd255;
    return v[7:0];
  endfunction

  function automatic logic [1023:0] rand_block();
    logic [1023:0] d;
    for (int i = 0; i < 32; i++)
      d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // Present a block and push its 64 expected pixels
  task automatic load_block(input logic [1023:0] d);
    logic [5:0] kk;
    blk_data  = d;
    blk_valid = 1'b1;
    for (int k = 0; k < 64; k++) begin
      kk = 6'(k);
      exp_q.push_back({kk == 6'd63, kk[5:3], kk[2:0],
                       ref_sat(d[k*16 +: 16])});
    end
  endtask

  // One clock: sample at negedge, update inputs 1 after posedge
  task automatic cyc(input bit hold, input bit rnd,
                     output logic [14:0] obs, output bit pv,
                     output bit phs, output bit br, output bit bhs);
    @(negedge clk);
    obs = {pix_last, pix_row, pix_col, pix_data};
    pv  = pix_valid;
    phs = pix_valid && pix_ready;
    br  = blk_ready;
    bhs = blk_valid && blk_ready;
    @(posedge clk);
    #1;
    if (bhs && !hold) blk_valid = 1'b0;
    pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    cyc_n++;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    blk_valid = 1'b0;
    pix_ready = 1'b1;
    blk_data  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tot++;
    if ({pix_valid, pix_last, pix_row, pix_col, pix_data} !== 15'd0)
      $display("FAIL reset_outs got=%h exp=0",
               {pix_valid, pix_last, pix_row, pix_col, pix_data});
    else pass++;
    tot++;
    if (blk_ready !== 1'b1)
      $display("FAIL reset_blk_ready got=%b exp=1", blk_ready);
    else pass++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_zero();
    logic [14:0] obs, e;
    bit pv, phs, br, bhs;
    int n = 0;
    pix_ready = 1'b1;
    load_block('0);
    for (int c = 0; c < 200 && n < 64; c++) begin
      cyc(0, 0, obs, pv, phs, br, bhs);
      if (phs) begin
        if (exp_q.size() != 0) e = exp_q.pop_front();
        else e = 'x;
        tot++;
        if (obs !== e)
          $display("FAIL zero_pix%0d got=%h exp=%h", n, obs, e);
        else pass++;
        n++;
      end
    end
    tot++;
    if (n !== 64) $display("FAIL zero_count got=%0d exp=64", n);
    else pass++;
    cyc(0, 0, obs, pv, phs, br, bhs);
    tot++;
    if ({pv, br} !== 2'b01)
      $display("FAIL zero_idle got=%b%b exp=01", pv, br);
    else pass++;
  endtask

  task automatic test_saturation();
    logic [14:0] obs, e;
    logic [1023:0] d;
    bit pv, phs, br, bhs;
    int n = 0;
    int vals[9] = '{-32768, -129, -128, -1, 0, 126, 127, 128, 32767};
    int ex[9]   = '{0, 0, 0, 127, 128, 254, 255, 255, 255};
    d = '0;
    for (int i = 0; i < 9; i++)
      d[(i*7)*16 +: 16] = 16'(vals[i]);
    load_block(d);
    for (int c = 0; c < 200 && n < 64; c++) begin
      cyc(0, 0, obs, pv, phs, br, bhs);
      if (phs) begin
        if (exp_q.size() != 0) e = exp_q.pop_front();
        else e = 'x;
        tot++;
        if (obs !== e)
          $display("FAIL sat_pix%0d got=%h exp=%h", n, obs, e);
        else pass++;
        if (n % 7 == 0 && n / 7 < 9) begin
          tot++;
          if (obs[7:0] !== 8'(ex[n/7]))
            $display("FAIL sat_val%0d got=%0d exp=%0d",
                     n / 7, obs[7:0], ex[n/7]);
          else pass++;
        end
        n++;
      end
    end
    tot++;
    if (n !== 64) $display("FAIL sat_count got=%0d exp=64", n);
    else pass++;
  endtask

  task automatic test_backpressure();
    logic [14:0] obs, e, prev;
    logic [1023:0] d;
    bit pv, phs, br, bhs, stall;
    int n = 0;
    int bad = 0;
    d = '0;
    for (int k = 0; k < 64; k++)
      d[k*16 +: 16] = 16'(k - 128);
    stall = 0;
    prev  = '0;
    load_block(d);
    for (int c = 0; c < 2000 && n < 64; c++) begin
      cyc(0, 1, obs, pv, phs, br, bhs);
      if (stall && pv && obs !== prev) bad++;
      stall = pv && !phs;
      prev  = obs;
      if (phs) begin
        if (exp_q.size() != 0) e = exp_q.pop_front();
        else e = 'x;
        tot++;
        if (obs !== e || obs[7:0] !== 8'(n))
          $display("FAIL bp_pix%0d got=%h exp=%h", n, obs, e);
        else pass++;
        n++;
      end
    end
    tot++;
    if (n !== 64) $display("FAIL bp_count got=%0d exp=64", n);
    else pass++;
    tot++;
    if (bad !== 0) $display("FAIL bp_stable got=%0d exp=0", bad);
    else pass++;
    pix_ready = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [14:0] obs, e;
    bit pv, phs, br, bhs;
    int n = 0;
    int nb = 0;
    int rdy = 0;
    int c_a63 = -1;
    int c_b0 = -1;
    int c_hs2 = -2;
    pix_ready = 1'b1;
    load_block(rand_block());
    for (int c = 0; c < 400 && n < 128; c++) begin
      cyc(1, 0, obs, pv, phs, br, bhs);
      if (nb < 2 && br) rdy++;
      if (phs) begin
        if (exp_q.size() != 0) e = exp_q.pop_front();
        else e = 'x;
        tot++;
        if (obs !== e)
          $display("FAIL b2b_pix%0d got=%h exp=%h", n, obs, e);
        else pass++;
        if (n == 63) c_a63 = cyc_n;
        if (n == 64) c_b0 = cyc_n;
        n++;
      end
      if (bhs) begin
        nb++;
        if (nb == 1) load_block(rand_block());
        if (nb == 2) begin
          c_hs2 = cyc_n;
          blk_valid = 1'b0;
        end
      end
    end
    tot++;
    if (n !== 128) $display("FAIL b2b_count got=%0d exp=128", n);
    else pass++;
    tot++;
    if (c_b0 - c_a63 !== 1)
      $display("FAIL b2b_gap got=%0d exp=1", c_b0 - c_a63);
    else pass++;
    tot++;
    if (c_hs2 !== c_a63)
      $display("FAIL b2b_hs got=%0d exp=%0d", c_hs2, c_a63);
    else pass++;
    tot++;
    if (rdy !== 2) $display("FAIL b2b_rdy got=%0d exp=2", rdy);
    else pass++;
  endtask

  task automatic test_midstream();
    logic [14:0] obs, e;
    bit pv, phs, br, bhs;
    int n = 0;
    int nb = 0;
    int bad = 0;
    int c_a63 = -1;
    int c_hs2 = -2;
    bit sent = 0;
    pix_ready = 1'b1;
    load_block(rand_block());
    for (int c = 0; c < 400 && n < 128; c++) begin
      cyc(0, 0, obs, pv, phs, br, bhs);
      if (sent && pv && !obs[14] && br) bad++;
      if (phs) begin
        if (exp_q.size() != 0) e = exp_q.pop_front();
        else e = 'x;
        tot++;
        if (obs !== e)
          $display("FAIL mid_pix%0d got=%h exp=%h", n, obs, e);
        else pass++;
        if (n == 63) c_a63 = cyc_n;
        n++;
      end
      if (bhs) begin
        nb++;
        if (nb == 2) c_hs2 = cyc_n;
      end
      if (n == 30 && !sent) begin
        sent = 1;
        load_block(rand_block());
      end
    end
    tot++;
    if (n !== 128) $display("FAIL mid_count got=%0d exp=128", n);
    else pass++;
    tot++;
    if (bad !== 0) $display("FAIL mid_rdy got=%0d exp=0", bad);
    else pass++;
    tot++;
    if (c_hs2 !== c_a63)
      $display("FAIL mid_hs got=%0d exp=%0d", c_hs2, c_a63);
    else pass++;
  endtask

  task automatic test_reset_mid();
    logic [14:0] obs, e;
    bit pv, phs, br, bhs;
    int n = 0;
    pix_ready = 1'b1;
    load_block(rand_block());
    for (int c = 0; c < 200 && n < 20; c++) begin
      cyc(0, 0, obs, pv, phs, br, bhs);
      if (phs) begin
        if (exp_q.size() != 0) e = exp_q.pop_front();
        else e = 'x;
        tot++;
        if (obs !== e)
          $display("FAIL rst_pre%0d got=%h exp=%h", n, obs, e);
        else pass++;
        n++;
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    tot++;
    if ({pix_valid, pix_row, pix_col} !== 7'd0)
      $display("FAIL rst_async got=%b exp=0",
               {pix_valid, pix_row, pix_col});
    else pass++;
    blk_valid = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n = 0;
    load_block(rand_block());
    for (int c = 0; c < 200 && n < 64; c++) begin
      cyc(0, 0, obs, pv, phs, br, bhs);
      if (phs) begin
        if (exp_q.size() != 0) e = exp_q.pop_front();
        else e = 'x;
        tot++;
        if (obs !== e)
          $display("FAIL rst_post%0d got=%h exp=%h", n, obs, e);
        else pass++;
        n++;
      end
    end
    tot++;
    if (n !== 64) $display("FAIL rst_count got=%0d exp=64", n);
    else pass++;
  endtask

  initial begin
    pass  = 0;
    tot   = 0;
    cyc_n = 0;
    test_reset();
    test_zero();
    test_saturation();
    test_backpressure();
    test_back_to_back();
    test_midstream();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass, tot);
    $finish;
  end

endmodule
